// File: rtl/nv_ram_pkg.sv
// rtl/nv_ram_pkg.sv - shared constants and helpers for the nv_ram small-RAM family
//
// Purpose: FSM state encoding for the clear sequencer, library default sizes and
//          the address-width / byte-count derivation helpers used by the RAMs.
// Ports:   none (package).

package nv_ram_pkg;

    localparam logic [0:0] NV_RAM_ST_IDLE  = 1'b0;
    localparam logic [0:0] NV_RAM_ST_CLEAR = 1'b1;

    localparam int NV_RAM_DEF_DEPTH = 256;
    localparam int NV_RAM_DEF_WIDTH = 64;

    // Address width for a power-of-2 depth; never below 1 so ports stay legal.
    function automatic int nv_ram_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Number of byte lanes in a word (used for the write mask width).
    function automatic int nv_ram_nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/nv_ram_rws_clr_seq.sv
// rtl/nv_ram_rws_clr_seq.sv - zero-fill sweep sequencer for nv_ram_rws_param
//
// Purpose: owns the IDLE/CLEAR FSM and sweep pointer. Comes out of reset in
//          CLEAR at pointer 0, writes one word per cycle, and returns to IDLE on
//          the edge that writes word DEPTH-1, pulsing clr_done_o for one cycle.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   clr_req_i   start a sweep (honoured only in IDLE)
//   busy_o      high while sweeping
//   clr_done_o  one-cycle pulse in the first IDLE cycle after a sweep
//   clr_we_o    array write strobe for the sweep
//   clr_addr_o  array address for the sweep

module nv_ram_rws_clr_seq
    import nv_ram_pkg::*;
#(
    parameter  int DEPTH = NV_RAM_DEF_DEPTH,
    localparam int AW    = nv_ram_aw(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          clr_done_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          clr_done_q, clr_done_d;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_done_d = 1'b0;
        case (state_q)
            NV_RAM_ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d    = NV_RAM_ST_IDLE;
                    ptr_d      = '0;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                if (clr_req_i) begin
                    state_d = NV_RAM_ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= NV_RAM_ST_CLEAR;
            ptr_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_done_q <= clr_done_d;
        end
    end

    // busy is decoded straight from state so it is already high during reset.
    assign busy_o     = (state_q == NV_RAM_ST_CLEAR);
    assign clr_we_o   = busy_o;
    assign clr_addr_o = ptr_q;
    assign clr_done_o = clr_done_q;

endmodule

// File: rtl/nv_ram_rws_param.sv
// rtl/nv_ram_rws_param.sv - parametrised 1W/1R RAM with registered read and clear sweep
//
// Purpose: DEPTH x WIDTH array, synchronous write port, synchronous read port
//          with a true output register and write-first forwarding on same-address
//          collisions. A built-in sequencer fills the array with CLR_VAL after
//          reset or on clr_req; user reads/writes are ignored while busy.
// Build option: NV_RAM_RWS_BYTE_WE_EN adds the per-byte wmask port.
// Ports:
//   nvdla_core_clk   clock, rising edge
//   nvdla_core_rstn  asynchronous active-low reset (array contents not reset)
//   ra, re, dout     read address, read enable, registered read data
//   wa, we, di       write address, write enable, write data
//   wmask            per-byte write enable (NV_RAM_RWS_BYTE_WE_EN only)
//   clr_req          pulse to start a clear sweep
//   busy             high while sweeping
//   clr_done         one-cycle pulse after the last word is cleared
//   pwrbus_ram_pd    power-down bus, unused

module nv_ram_rws_param
    import nv_ram_pkg::*;
#(
    parameter  int               DEPTH   = NV_RAM_DEF_DEPTH,
    parameter  int               WIDTH   = NV_RAM_DEF_WIDTH,
    parameter  logic [WIDTH-1:0] CLR_VAL = '0,
    localparam int               AW      = nv_ram_aw(DEPTH),
    localparam int               NB      = nv_ram_nbytes(WIDTH)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
`ifdef NV_RAM_RWS_BYTE_WE_EN
    input  logic [NB-1:0]    wmask,
`endif
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    input  logic [31:0]      pwrbus_ram_pd
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             user_we;
    logic             user_re;
    logic [WIDTH-1:0] fwd_data;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             unused_pwrbus;

    assign unused_pwrbus = ^pwrbus_ram_pd;

    nv_ram_rws_clr_seq #(
        .DEPTH (DEPTH)
    ) u_clr_seq (
        .clk_i      (nvdla_core_clk),
        .rst_ni     (nvdla_core_rstn),
        .clr_req_i  (clr_req),
        .busy_o     (busy),
        .clr_done_o (clr_done),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign user_we = we & ~busy;
    assign user_re = re & ~busy;

    // Array write mux: the sweep owns the port whenever it is running.
    always_ff @(posedge nvdla_core_clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLR_VAL;
        end else if (user_we) begin
`ifdef NV_RAM_RWS_BYTE_WE_EN
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) begin
                    mem[wa][b*8 +: 8] <= di[b*8 +: 8];
                end
            end
`else
            mem[wa] <= di;
`endif
        end
    end

    // Value the word at wa will hold after this edge's write, for write-first reads.
    always_comb begin
        fwd_data = di;
`ifdef NV_RAM_RWS_BYTE_WE_EN
        for (int b = 0; b < NB; b++) begin
            if (!wmask[b]) begin
                fwd_data[b*8 +: 8] = mem[wa][b*8 +: 8];
            end
        end
`endif
    end

    always_comb begin
        dout_d = dout_q;
        if (user_re) begin
            dout_d = (user_we && (ra == wa)) ? fwd_data : mem[ra];
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule
